// File: rtl/sqrt_pkg.sv
// sqrt_pkg: shared widths, latency and digit-recurrence helpers for the 48-bit integer square root
package sqrt_pkg;
    localparam int SQRT_IN_W  = 48;
    localparam int SQRT_OUT_W = 24;
    localparam int SQRT_LAT   = 8;
    localparam int SQRT_BPS   = SQRT_OUT_W / SQRT_LAT;
    localparam int SQRT_REM_W = SQRT_OUT_W + 4;

    typedef struct packed {
        logic [SQRT_IN_W-1:0]  x;
        logic [SQRT_REM_W-1:0] rem;
        logic [SQRT_OUT_W-1:0] root;
    } sqrt_st_t;

    // Retires SQRT_BPS result bits: bring down two operand bits, try (4*root+1), keep it if it fits.
    function automatic sqrt_st_t sqrt_step(input sqrt_st_t s);
        sqrt_st_t r;
        logic [SQRT_REM_W-1:0] trial;
        logic ge;
        r = s;
        for (int b = 0; b < SQRT_BPS; b++) begin
            r.rem  = {r.rem[SQRT_REM_W-3:0], r.x[SQRT_IN_W-1 -: 2]};
            r.x    = r.x << 2;
            trial  = {2'b00, r.root, 2'b01};
            ge     = r.rem >= trial;
            r.rem  = ge ? r.rem - trial : r.rem;
            r.root = {r.root[SQRT_OUT_W-2:0], ge};
        end
        return r;
    endfunction

    function automatic logic [SQRT_OUT_W-1:0] sqrt_last_root(input sqrt_st_t s);
        sqrt_st_t r;
        r = sqrt_step(s);
        return r.root;
    endfunction
endpackage

// File: rtl/sqrt_rsp_fifo.sv
// sqrt_rsp_fifo: synchronous FIFO of {id, root} results
//   clk/rst; push_i+din_i write; pop_i reads (ignored when empty); dout_o head; empty_o/full_o/count_o status.
module sqrt_rsp_fifo #(
    parameter int W     = 26,
    parameter int DEPTH = 16,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic [W-1:0]  din_i,
    input  logic          pop_i,
    output logic [W-1:0]  dout_o,
    output logic          empty_o,
    output logic          full_o,
    output logic [CW-1:0] count_o
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    logic [W-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q;
    logic do_pop;

    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
        return p == AW'(DEPTH - 1) ? '0 : p + AW'(1);
    endfunction

    assign do_pop  = pop_i && !empty_o;
    assign empty_o = cnt_q == '0;
    assign full_o  = cnt_q == CW'(DEPTH);
    assign count_o = cnt_q;
    assign dout_o  = mem_q[rd_q];

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_q] <= din_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= push_i ? nxt(wr_q) : wr_q;
            rd_q  <= do_pop ? nxt(rd_q) : rd_q;
            cnt_q <= cnt_q + CW'(push_i) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/sqrt_u48_8.sv
// sqrt_u48_8: pipelined floor(sqrt) of a 48-bit operand, 3 result bits per stage, 8-cycle latency
//   clk, en (stall when low), vldin/ain operand in; vldout/out result out.
//   Valid flags are deliberately not reset; callers track validity themselves.
module sqrt_u48_8
    import sqrt_pkg::*;
(
    input  logic                  clk,
    input  logic                  en,
    input  logic                  vldin,
    input  logic [SQRT_IN_W-1:0]  ain,
    output logic                  vldout,
    output logic [SQRT_OUT_W-1:0] out
);
    logic [SQRT_LAT-1:0] vld_q;
    sqrt_st_t [SQRT_LAT-2:0] st_q;
    logic [SQRT_OUT_W-1:0] root_q;
    sqrt_st_t st_in;

    assign st_in  = {ain, {(SQRT_REM_W + SQRT_OUT_W){1'b0}}};
    assign vldout = vld_q[SQRT_LAT-1];
    assign out    = root_q;

    always_ff @(posedge clk) begin
        if (en) begin
            vld_q    <= {vld_q[SQRT_LAT-2:0], vldin};
            st_q[0]  <= sqrt_step(st_in);
            for (int s = 1; s < SQRT_LAT - 1; s++) st_q[s] <= sqrt_step(st_q[s-1]);
            root_q   <= sqrt_last_root(st_q[SQRT_LAT-2]);
        end
    end
endmodule

// File: rtl/sqrt_u48_arb.sv
// sqrt_u48_arb: round-robin sharing of one pipelined 48-bit sqrt unit among NREQ requesters
//   clk/rst; req_vld/req_rdy/req_data per-requester request ports;
//   rsp_vld/rsp_rdy/rsp_id/rsp_data shared in-order response port; busy while work is outstanding.
module sqrt_u48_arb
    import sqrt_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int IDW        = 2,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NREQ-1:0]             req_vld,
    output logic [NREQ-1:0]             req_rdy,
    input  logic [NREQ*SQRT_IN_W-1:0]   req_data,
    output logic                        rsp_vld,
    input  logic                        rsp_rdy,
    output logic [IDW-1:0]              rsp_id,
    output logic [SQRT_OUT_W-1:0]       rsp_data,
    output logic                        busy
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int FW = IDW + SQRT_OUT_W;

    logic [IDW-1:0] ptr_q, ptr_d, gnt_id, idx;
    logic [CW-1:0] credits_q, credits_d, fifo_cnt;
    logic gnt_any, issue, pop, push, fifo_empty, fifo_full, sq_vldout;
    logic [SQRT_LAT-1:0] tag_vld_q;
    logic [SQRT_LAT-1:0][IDW-1:0] tag_id_q;
    logic [SQRT_IN_W-1:0] sq_ain;
    logic [SQRT_OUT_W-1:0] sq_out;
    logic [FW-1:0] fifo_dout;

    // Scan from farthest to nearest so the nearest requester after the pointer wins.
    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = '0;
        idx     = '0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = IDW'((int'(ptr_q) + k) % NREQ);
            if (req_vld[idx]) begin
                gnt_any = 1'b1;
                gnt_id  = idx;
            end
        end
        gnt_any = gnt_any && credits_q != '0 && !rst;
    end

    always_comb begin
        sq_ain = '0;
        for (int k = 0; k < NREQ; k++) sq_ain = gnt_id == IDW'(k) ? req_data[k*SQRT_IN_W +: SQRT_IN_W] : sq_ain;
    end

    assign req_rdy   = gnt_any ? NREQ'(1) << gnt_id : '0;
    assign issue     = gnt_any;
    assign ptr_d     = issue ? gnt_id : ptr_q;
    assign pop       = rsp_vld && rsp_rdy;
    assign credits_d = credits_q + CW'(pop) - CW'(issue);
    assign push      = tag_vld_q[SQRT_LAT-1];
    assign rsp_vld   = !fifo_empty;
    assign rsp_id    = rsp_vld ? fifo_dout[FW-1 -: IDW] : '0;
    assign rsp_data  = rsp_vld ? fifo_dout[SQRT_OUT_W-1:0] : '0;
    assign busy      = credits_q != CW'(FIFO_DEPTH);

    // The datapath's own valids are unreset, so validity rides in this reset-cleared tag pipe.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q     <= IDW'(NREQ - 1);
            credits_q <= CW'(FIFO_DEPTH);
            tag_vld_q <= '0;
            tag_id_q  <= '0;
        end else begin
            ptr_q     <= ptr_d;
            credits_q <= credits_d;
            tag_vld_q <= {tag_vld_q[SQRT_LAT-2:0], issue};
            tag_id_q  <= {tag_id_q[SQRT_LAT-2:0], gnt_id};
        end
    end

    sqrt_u48_8 u_sqrt (
        .clk    (clk),
        .en     (1'b1),
        .vldin  (issue),
        .ain    (sq_ain),
        .vldout (sq_vldout),
        .out    (sq_out)
    );

    sqrt_rsp_fifo #(.W(FW), .DEPTH(FIFO_DEPTH), .CW(CW)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .din_i   ({tag_id_q[SQRT_LAT-1], sq_out}),
        .pop_i   (pop),
        .dout_o  (fifo_dout),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .count_o (fifo_cnt)
    );

    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && fifo_full));
    a_tag_has_data: assert property (@(posedge clk) disable iff (rst) push |-> sq_vldout);
    a_credit_balance: assert property (@(posedge clk) disable iff (rst)
        int'(credits_q) + int'(fifo_cnt) + $countones(tag_vld_q) == FIFO_DEPTH);
endmodule

// File: tb/tb_sqrt_u48_arb.sv
// tb_sqrt_u48_arb: directed vectors checked against a queue-based model of the shared sqrt arbiter
module tb_sqrt_u48_arb;
    localparam int NREQ = 4, IDW = 2, DEPTH = 16, LAT = 8;

    logic clk = 1'b0, rst = 1'b1, rsp_rdy = 1'b0;
    logic [NREQ-1:0] req_vld = '0, req_rdy;
    logic [NREQ*48-1:0] req_data = '0;
    logic rsp_vld, busy;
    logic [IDW-1:0] rsp_id;
    logic [23:0] rsp_data;

    typedef struct {int id; logic [23:0] d; int c;} ent_t;
    ent_t exp_q[$], got[$], hlog[$];
    int vec = 0, err = 0, cyc = 0, ptr = NREQ - 1;

    sqrt_u48_arb #(.NREQ(NREQ), .IDW(IDW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .req_vld(req_vld), .req_rdy(req_rdy), .req_data(req_data),
        .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] isqrt(input logic [47:0] a);
        longint unsigned lo = 0, hi = 64'hFFFFFF, mid;
        while (lo < hi) begin
            mid = (lo + hi + 1) / 2;
            if (mid * mid <= {16'b0, a}) lo = mid;
            else hi = mid - 1;
        end
        return 24'(lo);
    endfunction

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        vec++;
        if (a !== e) begin
            err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, a, e, cyc);
        end
    endtask

    // Model: outstanding = exp_q size; grant = first valid after last grant; response visible LAT+1 cycles after issue.
    always @(negedge clk) begin
        logic [NREQ-1:0] er;
        logic ev;
        int gid;
        ent_t e;
        er = '0;
        ev = 1'b0;
        gid = -1;
        if (!rst && exp_q.size() < DEPTH)
            for (int k = 1; k <= NREQ && gid < 0; k++)
                if (req_vld[(ptr + k) % NREQ]) gid = (ptr + k) % NREQ;
        if (gid >= 0) er[gid] = 1'b1;
        chk("req_rdy", req_rdy, er);
        if (!rst) begin
            ev = exp_q.size() > 0 && exp_q[0].c <= cyc;
            chk("rsp_vld", rsp_vld, ev);
            chk("busy", busy, exp_q.size() != 0);
            if (ev) begin
                chk("rsp_id", rsp_id, exp_q[0].id);
                chk("rsp_data", rsp_data, exp_q[0].d);
            end
        end
        if (rst) begin
            exp_q.delete();
            ptr = NREQ - 1;
        end else begin
            if (ev && rsp_rdy) begin
                e = '{int'(rsp_id), rsp_data, cyc};
                got.push_back(e);
                void'(exp_q.pop_front());
            end
            if (gid >= 0) begin
                e = '{gid, isqrt(req_data[gid*48 +: 48]), cyc + LAT + 1};
                exp_q.push_back(e);
                e.c = cyc;
                hlog.push_back(e);
                ptr = gid;
            end
        end
        cyc++;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit tog);
        int k = 0;
        while (busy && k < n) begin
            if (tog) rsp_rdy = ~rsp_rdy;
            step(1);
            k++;
        end
        chk("idle_timeout", busy, 0);
    endtask

    task automatic clr();
        got.delete();
        hlog.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [47:0] bops[5] = '{48'h0, 48'h1, 48'h10, 48'hFFFFFFFFFFFF, 48'h3FFFFFFFFFFF};
        logic [23:0] bres[5] = '{24'h0, 24'h1, 24'h4, 24'hFFFFFF, 24'h7FFFFF};
        step(3);
        req_vld = '1;
        #1 chk("rst_gates_rdy", req_rdy, 0);
        req_vld = '0;
        step(1);
        rst = 1'b0;
        #1;
        chk("rst_rsp_vld", rsp_vld, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_req_rdy", req_rdy, 0);

        // single request from requester 2
        clr();
        rsp_rdy = 1'b1;
        req_data[2*48 +: 48] = 48'h400000000000;
        req_vld = 4'b0100;
        #1 chk("t1_grant", req_rdy, 4'b0100);
        step(1);
        req_vld = '0;
        idle(40, 0);
        chk("t1_count", got.size(), 1);
        if (got.size() == 1 && hlog.size() == 1) begin
            chk("t1_id", got[0].id, 2);
            chk("t1_data", got[0].d, 24'h800000);
            chk("t1_latency", got[0].c - hlog[0].c, 9);
        end

        // boundary operands from requester 0
        clr();
        req_vld = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            req_data[47:0] = bops[i];
            step(1);
        end
        req_vld = '0;
        idle(40, 0);
        chk("t2_count", got.size(), 5);
        for (int i = 0; i < 5 && i < got.size(); i++) begin
            chk("t2_id", got[i].id, 0);
            chk("t2_data", got[i].d, bres[i]);
        end

        // round-robin with all requesters active
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        clr();
        for (int i = 0; i < NREQ; i++) req_data[i*48 +: 48] = 48'((i + 3) * (i + 3));
        req_vld = '1;
        step(8);
        req_vld = '0;
        idle(40, 0);
        chk("t3_grants", hlog.size(), 8);
        chk("t3_count", got.size(), 8);
        for (int i = 0; i < 8 && i < hlog.size() && i < got.size(); i++) begin
            chk("t3_gnt_id", hlog[i].id, i % 4);
            chk("t3_gnt_cyc", hlog[i].c - hlog[0].c, i);
            chk("t3_rsp_id", got[i].id, i % 4);
            chk("t3_rsp_data", got[i].d, i % 4 + 3);
            chk("t3_rsp_cyc", got[i].c - got[0].c, i);
        end

        // backpressure: credits run out at FIFO_DEPTH grants
        clr();
        rsp_rdy = 1'b0;
        req_vld = 4'b0010;
        for (int k = 0; k < 24; k++) begin
            req_data[48 +: 48] = 48'(k * k + k);
            step(1);
        end
        chk("t4_grants", hlog.size(), 16);
        chk("t4_stalled", req_rdy, 0);
        rsp_rdy = 1'b1;
        for (int k = 24; k < 28; k++) begin
            req_data[48 +: 48] = 48'(k * k + k);
            step(1);
        end
        req_vld = '0;
        idle(80, 0);
        chk("t4_no_loss", got.size(), hlog.size());
        for (int i = 0; i < 16 && i < got.size(); i++) begin
            chk("t4_id", got[i].id, 1);
            chk("t4_data", got[i].d, i);
        end

        // simultaneous push/pop with toggling rsp_rdy
        clr();
        req_vld = '1;
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < NREQ; j++) req_data[j*48 +: 48] = 48'((i * 977 + j * 131 + 5) * (i * 3 + 11));
            rsp_rdy = ~rsp_rdy;
            step(1);
        end
        req_vld = '0;
        idle(100, 1);
        rsp_rdy = 1'b1;
        chk("t5_count", got.size(), 16);
        for (int i = 0; i < 16 && i < got.size() && i < hlog.size(); i++) begin
            chk("t5_order_id", got[i].id, hlog[i].id);
            chk("t5_order_data", got[i].d, hlog[i].d);
        end

        // reset with operations in flight
        clr();
        req_vld = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            req_data[47:0] = 48'(1000 + i);
            step(1);
        end
        req_vld = '0;
        step(4);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(12);
        chk("t6_discarded", got.size(), 0);
        clr();
        req_data[47:0] = 48'h40;
        req_data[3*48 +: 48] = 48'h19;
        req_vld = 4'b1001;
        #1 chk("t6_prio", req_rdy, 4'b0001);
        step(1);
        chk("t6_next", req_rdy, 4'b1000);
        step(1);
        req_vld = '0;
        idle(40, 0);
        chk("t6_count", got.size(), 2);
        if (got.size() == 2 && hlog.size() == 2) begin
            chk("t6_id0", got[0].id, 0);
            chk("t6_data0", got[0].d, 8);
            chk("t6_id3", got[1].id, 3);
            chk("t6_data3", got[1].d, 5);
            chk("t6_latency", got[1].c - hlog[1].c, 9);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule

// File: doc/sqrt_u48_arb.md
Name: sqrt_u48_arb

Overview:
- Shares one pipelined 48-bit unsigned integer square-root unit (sqrt_u48_8: 24-bit result, 8-cycle latency, one issue per cycle) between NREQ requesters.
- Round-robin arbitration on valid/ready request ports; a reset-cleared tag pipeline carries the requester ID beside each operation.
- Results return in issue order on one shared response port with backpressure, via a credit-guarded result FIFO.
- Sits between the FP/fixed-point units that need sqrt and the single shared sqrt datapath.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, requester ID width, equal to clog2(NREQ).
- FIFO_DEPTH, 16, result FIFO entries; must be at least SQRT_LAT+1 for full throughput.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- req_vld  in  NREQ  per-requester request valid.
- req_rdy  out  NREQ  per-requester grant; at most one bit high per cycle.
- req_data  in  NREQ*48  operands; requester i uses bits [48*i+47:48*i].
- rsp_vld  out  1  result available.
- rsp_rdy  in  1  consumer accepts the result.
- rsp_id  out  IDW  requester index of the result.
- rsp_data  out  24  floor(sqrt(operand)).
- busy  out  1  high while any operation is in flight or any result is held in the FIFO.

Behaviour:
- Reset values: req_rdy=0, rsp_vld=0, rsp_id=0, rsp_data=0, busy=0. Reset also sets: RR pointer=NREQ-1 (requester 0 has highest priority first), credits=FIFO_DEPTH, tag pipe valids all 0, FIFO empty.
- Arbitration:
  - req_rdy[i] is combinational. It is high for exactly one requester: the first with req_vld=1, searching upward from pointer+1 with wrap-around. This only happens when credits>0 and rst=0.
  - A handshake is req_vld[i]&req_rdy[i]. On a handshake the pointer becomes i. Otherwise the pointer holds.
  - req_rdy never depends on rsp_rdy combinationally.
- Issue:
  - The sqrt ain input is the granted operand through a combinational mux. vldin = handshake. en is tied 1.
  - Each issue decrements credits. Each FIFO pop (rsp_vld&rsp_rdy) increments credits.
  - Issue and pop in the same cycle leave credits unchanged. credits never exceeds FIFO_DEPTH and never goes below 0.
- Tag pipeline:
  - SQRT_LAT stages of {valid, id}. Stage 0 loads on every clock; later stages shift every clock.
  - Pipeline valid comes only from this reset-cleared tag pipe. sqrt vldout is ignored, because its internal valid registers are not reset.
  - The last-stage valid coincides with sqrt out being valid. In that cycle {id, out} is pushed into the FIFO.
- Latency: handshake at clock edge E0 gives the FIFO write at edge E0+SQRT_LAT. rsp_vld rises in the following cycle, i.e. the response appears SQRT_LAT+1 cycles after the request cycle.
- Response: rsp_vld = FIFO not empty. rsp_id and rsp_data show the FIFO head and hold stable while rsp_vld=1 and rsp_rdy=0.
- Ordering: results are in issue order, both globally and per requester.
- Overflow: the credit scheme guarantees a push never finds the FIFO full. A push to a full FIFO is a design error; it gets an assertion, not recovery logic.
- Simultaneous push and pop, including on an empty FIFO: both take effect. No bypass is provided, so rsp_vld for the pushed entry comes one cycle later.
- busy = (credits != FIFO_DEPTH).
- Reset mid-operation: all in-flight tags and FIFO contents are discarded and no response is emitted for them. Stale sqrt data still in the pipe is masked by the cleared tag valids.

Decomposition:
- Shared package sqrt_pkg: SQRT_IN_W=48, SQRT_OUT_W=24, SQRT_LAT=8.
- Sub-module sqrt_rsp_fifo: synchronous FIFO of width IDW+24 and depth FIFO_DEPTH with push, pop, empty, full and count.
- Top level: arbiter, credit counter, tag pipe, and the sqrt_u48_8 instance.

Test Plan:
- Single request: requester 2 sends 48'h400000000000 with rsp_rdy=1. The grant is seen in the same cycle; 9 cycles later rsp_vld=1, rsp_id=2, rsp_data=24'h800000. busy then falls.
- Boundary values from requester 0: operands 0, 1, 48'h10, 48'hFFFFFFFFFFFF and 48'h3FFFFFFFFFFF. Results are 0, 1, 4, 24'hFFFFFF and 24'h7FFFFF.
- Round-robin: all 4 requesters hold req_vld=1 for 8 cycles. Grants go 0,1,2,3,0,1,2,3, one per cycle. Responses arrive in the same ID order, back to back.
- Backpressure: rsp_rdy=0 with requester 1 streaming. Exactly 16 grants occur, then req_rdy stays 0. After rsp_rdy=1, each pop re-enables one grant; all 16 results come out in order with no loss or duplication.
- Simultaneous push/pop: FIFO_DEPTH requests are issued while rsp_rdy toggles every cycle. credits stays within 0..16, and the response order and IDs match the issue order.
- Reset mid-flight: rst is pulsed for 1 cycle 4 cycles after 3 issues. No rsp_vld appears afterwards. The next request, 48'h19 from requester 3, returns 5 with id 3 after 9 cycles, and requester 0 has highest priority after reset.
